cnn_acc_requant_25s_10s: RTL and testbench
==========================================

// Module: cnn_acc_requant_25s_10s
// PURPOSE
//  Consumer end of the conv-layer signed multiply path: accepts a stream of 25-bit signed
//  products (one kernel window per burst), accumulates them onto a bias, then rounds,
//  shifts and saturates the sum back to the 10-bit signed activation format.
//  Sits between the product multipliers and the next layer's 10-bit operand input.
// PARAMETERS
//  PROD_W  25  product input width (signed)
//  BIAS_W  16  bias width (signed, same fixed-point scale as products)
//  ACC_W   32  accumulator width (signed, saturating)
//  OUT_W   10  output activation width (signed)
//  SHIFT    8  arithmetic right shift applied at requantisation (0..ACC_W-2)
// PORTS
//  ap_clk      in   1        clock, all logic on rising edge
//  ap_rst      in   1        asynchronous, active-high reset
//  prod_din    in   PROD_W   signed product
//  prod_valid  in   1        product beat valid
//  prod_last   in   1        final beat of the current kernel window
//  prod_ready  out  1        block accepts a beat this cycle
//  bias        in   BIAS_W   signed bias, sampled on the first beat of a window
//  out_dout    out  OUT_W    requantised signed activation
//  out_valid   out  1        out_dout valid
//  out_ready   in   1        downstream accepts out_dout
//  sat_flag    out  1        result (or accumulator) saturated; qualified by out_valid
// BEHAVIOUR
//  - Reset (async assert, sync deassert): state=IDLE, acc=0, out_dout=0, out_valid=0, sat_flag=0.
//  - Beat accepted when prod_valid && prod_ready. States IDLE, ACC, HOLD.
//  - IDLE: prod_ready=1. A beat sets acc = sext(bias) + sext(prod_din); goes to ACC.
//    If prod_last is also set (one-beat window), the block goes straight to requant.
//  - ACC: prod_ready=1. Each beat sets acc = sat(acc + sext(prod_din)).
//    A beat with prod_last=1 triggers requant.
//  - Requant: registered on the edge that accepts the last beat.
//    r = (acc + (SHIFT ? 1<<(SHIFT-1) : 0)) >>> SHIFT. This is round-half-up, so -2.5 -> -2.
//    The sum is computed at ACC_W+1 bits, so it cannot overflow.
//    out_dout = clamp(r, -2^(OUT_W-1), 2^(OUT_W-1)-1).
//    sat_flag = clamp active OR any accumulator saturation during the window.
//    out_valid=1 next cycle (latency 1 from the last beat). State=HOLD.
//  - Accumulator saturation: the sum clamps to the ACC_W signed min/max.
//    A sticky bit records it; the bit clears when a new window starts.
//  - HOLD: out_dout, out_valid and sat_flag are held stable until out_ready.
//    prod_ready = out_ready, so the next window's first beat is accepted in the same cycle
//    as the output handshake. On that handshake: if a beat is also accepted it is treated
//    as an IDLE first beat; otherwise state=IDLE. out_valid drops unless a new result loads
//    on the same edge (only possible for a one-beat window).
//  - prod_valid=0 in ACC: the accumulator holds; there is no timeout.
//  - prod_din and prod_last are ignored when prod_valid=0. bias is only sampled on a first beat.
//  - Reset mid-window or in HOLD: the partial sum and any pending output are discarded;
//    all outputs return to their reset values.
// STRUCTURE
//  - Shared package cnn_fixpt_pkg: PROD_W/OUT_W/ACC_W defaults, the state enum
//    (IDLE/ACC/HOLD), and sat-bound constants.
//  - Sub-module cnn_requant_sat (combinational): acc, SHIFT -> rounded, clamped out and a
//    clamp flag. The top file holds the FSM, the accumulator and the output registers.
// TESTING (SHIFT=8, BIAS_W=16, out_ready=1 unless stated)
//  1. Beats 256, 384 (last), bias=0 -> acc=640; next cycle out_dout=3, sat_flag=0.
//  2. Beats -256, -384 (last), bias=0 -> out_dout=-2 (round-half-up of -2.5), sat_flag=0.
//  3. One beat 16777215 with last, bias=0 -> out_dout=511, sat_flag=1.
//     One beat -16777216 with last -> out_dout=-512, sat_flag=1.
//  4. out_ready=0 for 5 cycles after a result -> out_dout/out_valid stable and prod_ready=0
//     throughout; raising out_ready together with a new first beat -> the beat is accepted
//     and out_valid deasserts next cycle.
//  5. 200 beats of 16777215, bias=32767 -> accumulator clamps at 2^31-1; out_dout=511,
//     sat_flag=1. The following window 1, 1 (last), bias=0 -> out_dout=0, sat_flag=0.
//  6. ap_rst pulsed mid-window (after 3 beats) and again in HOLD -> out_valid=0 immediately.
//     A fresh window 512 (last), bias=256 -> out_dout=3 (768+128=896>>>8).

Source files
------------

// File: rtl/cnn_fixpt_pkg.sv
// Shared fixed-point defaults, FSM state encoding and signed saturation bounds
// for the conv-layer accumulate/requantise path.
package cnn_fixpt_pkg;

  localparam int PROD_W_DEF = 25;
  localparam int BIAS_W_DEF = 16;
  localparam int ACC_W_DEF  = 32;
  localparam int OUT_W_DEF  = 10;
  localparam int SHIFT_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Largest / smallest value of a w-bit two's complement number.
  function automatic longint smax(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint smin(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/cnn_requant_sat.sv
// Combinational requantiser: round-half-up, arithmetic shift, clamp to OUT_W.
// The rounding sum uses one guard bit so it cannot wrap.
module cnn_requant_sat
  import cnn_fixpt_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clamp
);

  // Half an output LSB; zero when SHIFT is zero.
  localparam logic signed [ACC_W:0] RND  = ((ACC_W+1)'(1) <<< SHIFT) >>> 1;
  localparam logic signed [ACC_W:0] OMAX = (ACC_W+1)'(smax(OUT_W));
  localparam logic signed [ACC_W:0] OMIN = (ACC_W+1)'(smin(OUT_W));

  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] r;

  always_comb begin
    sum   = (ACC_W+1)'(acc) + RND;
    r     = sum >>> SHIFT;
    clamp = 1'b0;
    dout  = r[OUT_W-1:0];
    if (r > OMAX) begin
      dout  = OMAX[OUT_W-1:0];
      clamp = 1'b1;
    end else if (r < OMIN) begin
      dout  = OMIN[OUT_W-1:0];
      clamp = 1'b1;
    end
  end

endmodule

// File: rtl/cnn_acc_requant_25s_10s.sv
// Accumulates a window of signed products onto a bias with a saturating
// accumulator, then registers the requantised 10-bit result (latency 1 from last beat).
module cnn_acc_requant_25s_10s
  import cnn_fixpt_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int BIAS_W = BIAS_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int SHIFT  = SHIFT_DEF
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic signed [PROD_W-1:0] prod_din,
  input  logic                     prod_valid,
  input  logic                     prod_last,
  output logic                     prod_ready,
  input  logic signed [BIAS_W-1:0] bias,
  output logic signed [OUT_W-1:0]  out_dout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sat_flag
);

  localparam logic signed [ACC_W-1:0] A_MAX = ACC_W'(smax(ACC_W));
  localparam logic signed [ACC_W-1:0] A_MIN = ACC_W'(smin(ACC_W));

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W:0]   sum;
  logic                    acc_sat;
  logic                    acc_sat_next;
  logic                    ovf;
  logic                    beat;
  logic                    first;
  logic signed [OUT_W-1:0] q_dout;
  logic                    q_clamp;

  // In HOLD the next window may only start alongside the output handshake.
  assign prod_ready = (state != ST_HOLD) || out_ready;
  assign beat       = prod_valid && prod_ready;
  assign first      = (state != ST_ACC);

  always_comb begin
    if (first) sum = (ACC_W+1)'(bias) + (ACC_W+1)'(prod_din);
    else       sum = (ACC_W+1)'(acc)  + (ACC_W+1)'(prod_din);
    ovf          = sum[ACC_W] != sum[ACC_W-1];
    acc_next     = ovf ? (sum[ACC_W] ? A_MIN : A_MAX) : sum[ACC_W-1:0];
    acc_sat_next = (!first && acc_sat) || ovf;
  end

  cnn_requant_sat #(
    .ACC_W(ACC_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_requant (
    .acc  (acc_next),
    .dout (q_dout),
    .clamp(q_clamp)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      acc_sat   <= 1'b0;
      out_dout  <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      if (state == ST_HOLD && out_ready) begin
        out_valid <= 1'b0;
        state     <= ST_IDLE;
      end
      // A beat accepted in the same cycle overrides the handshake defaults above.
      if (beat) begin
        acc     <= acc_next;
        acc_sat <= acc_sat_next;
        if (prod_last) begin
          out_dout  <= q_dout;
          sat_flag  <= q_clamp || acc_sat_next;
          out_valid <= 1'b1;
          state     <= ST_HOLD;
        end else begin
          state <= ST_ACC;
        end
      end
    end
  end

endmodule

// File: tb/tb_cnn_acc_requant_25s_10s.sv
// Directed bench for the accumulate/requantise block with a window-level reference model.
module tb_cnn_acc_requant_25s_10s;

  logic               ap_clk = 1'b0;
  logic               ap_rst = 1'b1;
  logic signed [24:0] prod_din = '0;
  logic               prod_valid = 1'b0;
  logic               prod_last = 1'b0;
  logic               prod_ready;
  logic signed [15:0] bias = '0;
  logic signed [9:0]  out_dout;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic               sat_flag;

  int checks = 0;
  int failures = 0;

  typedef struct {
    longint d;
    bit     s;
  } exp_t;

  exp_t   exp_q[$];
  longint macc = 0;
  bit     msat = 1'b0;
  bit     in_win = 1'b0;

  cnn_acc_requant_25s_10s dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .prod_din  (prod_din),
    .prod_valid(prod_valid),
    .prod_last (prod_last),
    .prod_ready(prod_ready),
    .bias      (bias),
    .out_dout  (out_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_flag  (sat_flag)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Window-level model: accepted beat updates the saturating sum; the last beat yields a result.
  task automatic model_beat(input longint p, input bit l, input longint b);
    longint r;
    bit     c;
    if (!in_win) begin
      macc = b + p;
      msat = 1'b0;
    end else begin
      macc = macc + p;
    end
    if (macc > 64'sd2147483647) begin macc = 64'sd2147483647; msat = 1'b1; end
    if (macc < -64'sd2147483648) begin macc = -64'sd2147483648; msat = 1'b1; end
    in_win = !l;
    if (l) begin
      r = (macc + 128) >>> 8;
      c = 1'b0;
      if (r > 511)  begin r = 511;  c = 1'b1; end
      if (r < -512) begin r = -512; c = 1'b1; end
      exp_q.push_back('{d: r, s: c || msat});
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge once accepted.
  task automatic send(input longint p, input bit l, input longint b);
    int n = 0;
    prod_din   = 25'(p);
    prod_last  = l;
    bias       = 16'(b);
    prod_valid = 1'b1;
    #1;
    while (!prod_ready && n < 50) begin
      @(negedge ap_clk);
      #1;
      n++;
    end
    if (!prod_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: prod_ready got 0 expected 1");
    end else begin
      model_beat(p, l, b);
    end
    @(negedge ap_clk);
  endtask

  task automatic idle(input int n);
    prod_valid = 1'b0;
    prod_din   = 25'h1abcde;
    prod_last  = 1'b1;
    repeat (n) @(negedge ap_clk);
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    exp_q.delete();
    in_win = 1'b0;
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_dout", longint'(out_dout), 0);
    chk("rst_sat_flag", longint'(sat_flag), 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
  endtask

  // Every output handshake is scored against the model queue.
  always @(negedge ap_clk) begin
    #2;
    if (!ap_rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("model_dout", longint'(out_dout), e.d);
        chk("model_sat", longint'(sat_flag), longint'(e.s));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  initial begin
    @(negedge ap_clk);
    do_reset();
    chk("rst_prod_ready", longint'(prod_ready), 1);

    // 1: 256 + 384 with a gap of invalid cycles in between.
    send(256, 0, 0);
    idle(2);
    send(384, 1, 0);
    chk("t1_valid", longint'(out_valid), 1);
    chk("t1_dout", longint'(out_dout), 3);
    chk("t1_sat", longint'(sat_flag), 0);
    idle(1);

    // 2: round-half-up of -2.5.
    send(-256, 0, 0);
    send(-384, 1, 0);
    chk("t2_dout", longint'(out_dout), -2);
    chk("t2_sat", longint'(sat_flag), 0);

    // 3: back-to-back one-beat windows, reloading on the handshake edge.
    send(16777215, 1, 0);
    chk("t3a_dout", longint'(out_dout), 511);
    chk("t3a_sat", longint'(sat_flag), 1);
    send(-16777216, 1, 0);
    chk("t3b_valid", longint'(out_valid), 1);
    chk("t3b_dout", longint'(out_dout), -512);
    chk("t3b_sat", longint'(sat_flag), 1);
    idle(1);

    // 4: hold under backpressure, then handshake together with a new first beat.
    out_ready = 1'b0;
    send(1000, 1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", longint'(out_valid), 1);
      chk("t4_hold_dout", longint'(out_dout), 4);
      chk("t4_hold_ready", longint'(prod_ready), 0);
      @(negedge ap_clk);
    end
    out_ready = 1'b1;
    send(512, 0, 256);
    chk("t4_valid_drop", longint'(out_valid), 0);
    send(0, 1, 0);
    chk("t4_dout", longint'(out_dout), 3);
    idle(1);

    // 5: accumulator saturation, then the sticky bit clears on the next window.
    for (int i = 0; i < 200; i++) send(16777215, i == 199, 32767);
    chk("t5_dout", longint'(out_dout), 511);
    chk("t5_sat", longint'(sat_flag), 1);
    send(1, 0, 0);
    send(1, 1, 0);
    chk("t5b_dout", longint'(out_dout), 0);
    chk("t5b_sat", longint'(sat_flag), 0);
    idle(1);

    // 6: reset mid-window and in HOLD.
    send(1000, 0, 0);
    send(1000, 0, 0);
    send(1000, 0, 0);
    do_reset();
    out_ready = 1'b0;
    send(16777215, 1, 0);
    chk("t6_hold_valid", longint'(out_valid), 1);
    do_reset();
    out_ready = 1'b1;
    send(512, 1, 256);
    chk("t6_dout", longint'(out_dout), 3);
    chk("t6_sat", longint'(sat_flag), 0);
    idle(3);

    chk("queue_drained", longint'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
